// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - Wishbone classic single-transfer host master
// Purpose: turns one valid/ready command into exactly one Wishbone classic
//   bus cycle against the user-project window and returns exactly one
//   response (read data, or a timeout error when the timeout is built in).
// Build option: define WB_HOST_MASTER_TIMEOUT_EN to include the bus timeout
//   counter; without it the bus cycle waits for ack indefinitely and rsp_err
//   is always 0.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_we/off/dat/sel      command: direction, word offset, write data, lanes
//   rsp_valid/rsp_ready     response handshake
//   rsp_dat/rsp_err         response: read data (0 for writes/errors), timeout
//   wbm_*                   Wishbone classic master signals
//   busy                    high whenever a transfer or response is pending
module wb_host_master #(
    parameter int                       WB_ADDR_WIDTH  = 32,
    parameter int                       WB_DATA_WIDTH  = 32,
    parameter int                       OFFSET_WIDTH   = 16,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h30000000,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter int                       TIMEOUT_WIDTH  = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [OFFSET_WIDTH-1:0]  cmd_off,
    input  logic [WB_DATA_WIDTH-1:0] cmd_dat,
    input  logic [3:0]               cmd_sel,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WB_DATA_WIDTH-1:0] rsp_dat,
    output logic                     rsp_err,

    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [3:0]               wbm_sel_o,
    output logic [WB_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wbm_dat_o,
    input  logic                     wbm_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wbm_dat_i,

    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     we_q, we_d;
    logic [3:0]               sel_q, sel_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [WB_DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                     err_q, err_d;
    logic                     cyc_q, cyc_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     busy_q, busy_d;
    logic                     cmd_ready_q, cmd_ready_d;

    // Word offset to byte address; the sum wraps at the bus address width.
    logic [WB_ADDR_WIDTH-1:0] off_addr;
    assign off_addr = WB_ADDR_WIDTH'({cmd_off, 2'b00});

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    // Counter value on the last permitted no-ack edge of the bus cycle.
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_WIDTH};
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = BASE_ADDR + off_addr;
                    wdat_d  = cmd_dat;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // Ack has priority over a timeout on the same edge.
                if (wbm_ack_i) begin
                    rdat_d  = we_q ? '0 : wbm_dat_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef WB_HOST_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdat_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next state so nothing
        // reaches an output combinationally from wbm_ack_i.
        cyc_d       = (state_d == S_BUS);
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rdat_q;
    assign rsp_err   = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - directed self-checking bench for wb_host_master
module tb_wb_host_master;

`ifdef WB_HOST_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYCLES = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_off = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic        busy;

    always #5 clk = ~clk;

    wb_host_master dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_off  (cmd_off),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i),
        .busy     (busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc_hi = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding command on the bus, or one
    // response waiting to be consumed, or nothing.
    bit          m_on_bus, m_rsp;
    int          m_wait;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_wdat, m_rdat;
    logic        m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_on_bus = 0; m_rsp = 0; m_wait = 0;
            m_we = 0; m_sel = 0; m_adr = 0; m_wdat = 0; m_rdat = 0; m_err = 0;
        end else if (m_on_bus) begin
            if (wbm_ack_i) begin
                m_rdat = m_we ? 32'h0 : wbm_dat_i;
                m_err = 0; m_on_bus = 0; m_rsp = 1;
            end else begin
                m_wait = m_wait + 1;
                if (TO_EN && m_wait == TO_CYCLES) begin
                    m_rdat = 0; m_err = 1; m_on_bus = 0; m_rsp = 1;
                end
            end
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp = 0;
        end else if (cmd_valid) begin
            m_we = cmd_we; m_sel = cmd_sel; m_wdat = cmd_dat;
            m_adr = 32'h30000000 + ({16'h0, cmd_off} * 32'd4);
            m_wait = 0; m_on_bus = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc", wbm_cyc_o, m_on_bus);
            chk("stb", wbm_stb_o, m_on_bus);
            chk("busy", busy, m_on_bus | m_rsp);
            chk("cmd_ready", cmd_ready, !(m_on_bus | m_rsp));
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_on_bus) begin
                chk("bus_adr", wbm_adr_o, m_adr);
                chk("bus_dat", wbm_dat_o, m_wdat);
                chk("bus_we", wbm_we_o, m_we);
                chk("bus_sel", wbm_sel_o, m_sel);
            end
            if (m_rsp) begin
                chk("rsp_dat", rsp_dat, m_rdat);
                chk("rsp_err", rsp_err, m_err);
            end
        end
    end

    always @(negedge clk) if (wbm_cyc_o === 1'b1) cyc_hi++;

    // Call at a negedge with the DUT idle; returns at the negedge of the
    // first bus cycle.
    task automatic issue(input logic we, input logic [15:0] off,
                         input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1; cmd_we = we; cmd_off = off; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_adr", wbm_adr_o, 0);
        chk("reset_rsp_dat", rsp_dat, 0);

        // Zero-wait write to the opcode register.
        cyc_hi = 0;
        issue(1'b1, 16'h0000, 32'h00000003, 4'hF);
        chk("wr_adr", wbm_adr_o, 32'h30000000);
        chk("wr_we", wbm_we_o, 1);
        chk("wr_dat", wbm_dat_o, 32'h00000003);
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_dat", rsp_dat, 0);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_cyc_len", cyc_hi, 1);
        @(negedge clk);

        // Read with four wait states.
        cyc_hi = 0;
        issue(1'b0, 16'h0001, 32'h0, 4'h3);
        chk("rd_adr", wbm_adr_o, 32'h30000004);
        repeat (4) @(negedge clk);
        wbm_dat_i = 32'hDEADBEEF;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        chk("rd_cyc_len", cyc_hi, 5);
        chk("rd_rsp_dat", rsp_dat, 32'hDEADBEEF);
        @(negedge clk);

        // Response backpressure with a command pulse that must be ignored.
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0003, 32'h0, 4'h5);
        wbm_dat_i = 32'h12345678;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_dat", rsp_dat, 32'h12345678);
            chk("bp_cmd_ready", cmd_ready, 0);
            if (i == 3) begin
                cmd_valid = 1'b1; cmd_we = 1'b1; cmd_off = 16'h0009;
            end
            if (i == 4) cmd_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", cmd_ready, 1);
        @(negedge clk);
        chk("bp_no_stray_cmd", wbm_cyc_o, 0);

        // Reset on the second wait cycle of a write.
        issue(1'b1, 16'h0007, 32'h0000A5A5, 4'hC);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_dat", wbm_dat_o, 0);
        chk("rst_sel", wbm_sel_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_no_rsp", rsp_valid, 0);

        // Address wrap, then a stray ack while idle.
        issue(1'b0, 16'hFFFF, 32'h0, 4'hF);
        chk("wrap_adr", wbm_adr_o, 32'h3003FFFC);
        wbm_dat_i = 32'hCAFEF00D;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        chk("wrap_rsp_dat", rsp_dat, 32'hCAFEF00D);
        @(negedge clk);
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk("stray_ack_rsp", rsp_valid, 0);
        chk("stray_ack_busy", busy, 0);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
        // Slave never acks: abort after the timeout, late ack ignored.
        rsp_ready = 1'b0;
        cyc_hi = 0;
        issue(1'b0, 16'h0002, 32'h0, 4'hF);
        repeat (TO_CYCLES - 1) @(negedge clk);
        chk("to_last_cyc", wbm_cyc_o, 1);
        @(negedge clk);
        chk("to_cyc_len", cyc_hi, 255);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_dat", rsp_dat, 0);
        repeat (3) @(negedge clk);
        wbm_dat_i = 32'h55AA55AA;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        chk("late_ack_busy", busy, 1);
        chk("late_ack_err", rsp_err, 1);
        chk("late_ack_dat", rsp_dat, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("to_done_busy", busy, 0);
`else
        // No timeout built in: the bus cycle waits well past 255 cycles.
        cyc_hi = 0;
        issue(1'b0, 16'h0002, 32'h0, 4'hF);
        repeat (299) @(negedge clk);
        chk("noto_cyc_held", wbm_cyc_o, 1);
        wbm_dat_i = 32'h0BADF00D;
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        chk("noto_cyc_len", cyc_hi, 300);
        chk("noto_rsp_err", rsp_err, 0);
        chk("noto_rsp_dat", rsp_dat, 32'h0BADF00D);
        @(negedge clk);
        chk("noto_done_busy", busy, 0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
